uart_rx_cfg: RTL and testbench
==============================

# uart_rx_cfg

Configurable, oversampling UART receiver. It is the next-generation serial receive path, with these capabilities:
- parameterised data width and oversampling ratio;
- runtime-selectable parity and stop-bit count;
- input synchronisation;
- parity, framing, break and overrun detection;
- a valid/ready output handshake.

It sits between the shared baud-tick generator and the receive FIFO or host logic.

## Interface
- DATA_BITS, 8, payload bits per frame; legal 5..9.
- OVERSAMPLE, 16, ticks per bit period; even, legal 8..32.
- clk  input  1  system clock.
- reset_n  input  1  reset; asynchronous, active-low; clock clk.
- tick  input  1  one-clk strobe at baud×OVERSAMPLE.
- rx  input  1  asynchronous serial line; idles high.
- parity_mode  input  2  00 none, 01 even, 10 odd, 11 none.
- stop_bits  input  1  0 = one stop bit, 1 = two stop bits.
- rx_ready  input  1  consumer accepts the current word.
- rx_data  output  DATA_BITS  received payload, LSB first on the line.
- rx_valid  output  1  rx_data and the flags are valid.
- parity_err  output  1  parity mismatch on the held word.
- frame_err  output  1  a stop bit was sampled low.
- break_det  output  1  line was low for the whole frame.
- overrun  output  1  the previous unconsumed word was overwritten.

## Operation
- **Input synchroniser:** `rx` passes through a 2-flop synchroniser. Both flops reset to 1. All sampling uses the synchronised value.
- **Tick gating:** the FSM and counters advance only on cycles with `tick`=1. The handshake logic runs every clk.
- **Counter widths:**
  - Tick counter `s`: $clog2(OVERSAMPLE) bits.
  - Bit counter `n`: $clog2(DATA_BITS+1) bits.
- **FSM states:** IDLE, START, DATA, PARITY, STOP1, STOP2.
- **IDLE:** synchronised rx=0 → go to START, s=0, n=0.
- **START:**
  - At s==OVERSAMPLE/2-1, if rx=0: latch parity_mode and stop_bits, go to DATA, s=0.
  - At that point, if rx=1: glitch; return to IDLE with no output.
  - Otherwise s++.
- **DATA:**
  - At s==OVERSAMPLE-1: shift[n]=rx, s=0.
  - If n==DATA_BITS-1: go to PARITY when parity is enabled, else STOP1.
  - Otherwise n++ and s++ on each intervening tick.
- **PARITY:** at s==OVERSAMPLE-1, store the parity bit, s=0, go to STOP1.
- **Parity check (parity enabled):**
  - Even: XOR(data, parity bit) must be 0.
  - Odd: XOR(data, parity bit) must be 1.
  - With parity disabled, parity_err=0.
- **STOP1:** at s==OVERSAMPLE-1, record the stop sample.
  - If the latched stop_bits=1: go to STOP2, s=0.
  - Otherwise complete the frame.
- **STOP2:** at s==OVERSAMPLE-1, record the stop sample and complete the frame.
- **Frame completion** (on the same tick):
  - rx_data ← shift.
  - frame_err ← any stop sample is 0.
  - break_det ← all data bits, the parity bit (if present) and the first stop sample are 0.
  - parity_err per the rule above.
  - rx_valid ← 1.
  - FSM → IDLE.
- **Latched configuration:** parity_mode and stop_bits changes after start confirmation do not affect the frame in flight.
- **Handshake:**
  - rx_valid stays high until a cycle with rx_valid & rx_ready. It clears on the next edge unless a completion occurs in that same cycle.
  - Completion while rx_valid=1 and rx_ready=0: rx_data and the flags are overwritten and overrun←1.
  - Completion in the same cycle as a handshake: the new word is loaded, rx_valid stays 1, overrun←0.
  - overrun and the error flags clear on handshake and are updated only at completion.
- **Break in progress:** after break_det, the receiver stays in IDLE until rx returns high. No new start is accepted until rx has been sampled high on at least one tick.

## Timing
- **Reset values:** rx_data=0, rx_valid=0, parity_err=0, frame_err=0, break_det=0, overrun=0. FSM=IDLE, s=0, n=0.
- **Reset mid-frame:** asserting reset_n mid-frame aborts the frame immediately (asynchronous). No partial word is ever presented.
- **Input latency:** 2 clk of synchroniser delay from the rx pin.
- **Output latency:** rx_valid and the flags assert on the clk edge following the tick that samples the final stop bit. They are registered, with no combinational path from rx or rx_ready.
- **Sampling points:** all bits are sampled at bit centre, OVERSAMPLE/2 ticks after the falling edge plus k×OVERSAMPLE ticks.
- **Frame length to completion:** OVERSAMPLE/2 + OVERSAMPLE×(DATA_BITS + P + S) ticks after start detect, where P ∈ {0,1} (parity bit present) and S ∈ {1,2} (stop bits).
- **Re-arm:** after completion, the next start can be detected on the next tick. A back-to-back frame starting half a bit later is received correctly.

## Test plan
- **8N1:** frame 0xA5 at OVERSAMPLE=16, rx_ready=1 → rx_data=0xA5, rx_valid high for 1 clk, all flags 0.
- **8E1 and 8O1:** 0x3C with correct parity → parity_err=0. Same frame with the parity bit flipped → parity_err=1, rx_data=0x3C.
- **Glitch:** rx low for 5 ticks, then high → no rx_valid, FSM back in IDLE. A valid 0x55 that follows is received.
- **Break:** rx low for 12 bit times, 8N1 → rx_data=0x00, frame_err=1, break_det=1. No second word until rx has gone high.
- **Overrun:** 0x11 then 0x22 with rx_ready=0 → rx_data=0x22, overrun=1. Pulse rx_ready → rx_valid=0 and overrun=0 next clk.
- **Reset and stop bits:**
  - 8N2 with the second stop bit low → frame_err=1.
  - reset_n pulsed mid-DATA → all outputs 0, the next 0x81 frame is received correctly.

Source files
------------

// File: rtl/uart_rx_cfg.sv
// Oversampling UART receiver with runtime parity/stop configuration, error
// flags (parity, framing, break, overrun) and a valid/ready output handshake.
module uart_rx_cfg #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 tick,
  input  logic                 rx,
  input  logic [1:0]           parity_mode,
  input  logic                 stop_bits,
  input  logic                 rx_ready,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 break_det,
  output logic                 overrun
);

  localparam int S_W = $clog2(OVERSAMPLE);
  localparam int N_W = $clog2(DATA_BITS + 1);
  localparam logic [S_W-1:0] S_LAST = S_W'(OVERSAMPLE - 1);
  localparam logic [S_W-1:0] S_MID  = S_W'(OVERSAMPLE / 2 - 1);
  localparam logic [N_W-1:0] N_LAST = N_W'(DATA_BITS - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP1, STOP2} state_t;

  state_t               state;
  logic [S_W-1:0]       s;
  logic [N_W-1:0]       n;
  logic [DATA_BITS-1:0] shift;
  logic                 rx_meta, rx_sync;
  logic [1:0]           cfg_par;
  logic                 cfg_stop;
  logic                 par_q, stop1_q, brk_hold;

  logic par_en, at_last, frame_done, stop_first, stop_err, par_calc_err, brk;

  // NOTE: both synchroniser flops reset high so reset release never looks like a start bit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) {rx_sync, rx_meta} <= 2'b11;
    else          {rx_sync, rx_meta} <= {rx_meta, rx};
  end

  // Completion-tick decode; the flags are computed from the frame in flight.
  always_comb begin
    par_en     = (cfg_par == 2'b01) || (cfg_par == 2'b10);
    at_last    = tick && (s == S_LAST);
    frame_done = 1'b0;
    stop_first = stop1_q;
    stop_err   = 1'b0;
    if (at_last && state == STOP1 && !cfg_stop) begin
      frame_done = 1'b1;
      stop_first = rx_sync;
      stop_err   = !rx_sync;
    end
    if (at_last && state == STOP2) begin
      frame_done = 1'b1;
      stop_err   = !stop1_q || !rx_sync;
    end
    par_calc_err = par_en && ((^shift ^ par_q) != (cfg_par == 2'b10));
    brk          = (shift == '0) && !(par_en && par_q) && !stop_first;
  end

  // NOTE: all state here uses non-blocking assignments so every branch sees pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      s          <= '0;
      n          <= '0;
      shift      <= '0;
      cfg_par    <= 2'b00;
      cfg_stop   <= 1'b0;
      par_q      <= 1'b0;
      stop1_q    <= 1'b1;
      brk_hold   <= 1'b0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      break_det  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if (rx_valid && rx_ready) begin
        rx_valid   <= 1'b0;
        parity_err <= 1'b0;
        frame_err  <= 1'b0;
        break_det  <= 1'b0;
        overrun    <= 1'b0;
      end
      // A completion overrides the handshake clear in the same cycle.
      if (frame_done) begin
        rx_data    <= shift;
        rx_valid   <= 1'b1;
        parity_err <= par_calc_err;
        frame_err  <= stop_err;
        break_det  <= brk;
        overrun    <= rx_valid && !rx_ready;
        if (brk) brk_hold <= 1'b1;
      end

      if (tick) begin
        case (state)
          IDLE: begin
            if (brk_hold) begin
              if (rx_sync) brk_hold <= 1'b0;
            end else if (!rx_sync) begin
              state <= START;
              s     <= '0;
              n     <= '0;
            end
          end
          START: begin
            if (s == S_MID) begin
              s <= '0;
              if (!rx_sync) begin
                state    <= DATA;
                cfg_par  <= parity_mode;
                cfg_stop <= stop_bits;
              end else begin
                state <= IDLE;
              end
            end else begin
              s <= s + 1'b1;
            end
          end
          DATA: begin
            if (s == S_LAST) begin
              shift <= {rx_sync, shift[DATA_BITS-1:1]};
              s     <= '0;
              if (n == N_LAST) begin
                n     <= '0;
                state <= par_en ? PARITY : STOP1;
              end else begin
                n <= n + 1'b1;
              end
            end else begin
              s <= s + 1'b1;
            end
          end
          PARITY: begin
            if (s == S_LAST) begin
              par_q <= rx_sync;
              s     <= '0;
              state <= STOP1;
            end else begin
              s <= s + 1'b1;
            end
          end
          STOP1: begin
            if (s == S_LAST) begin
              stop1_q <= rx_sync;
              s       <= '0;
              state   <= cfg_stop ? STOP2 : IDLE;
            end else begin
              s <= s + 1'b1;
            end
          end
          STOP2: begin
            if (s == S_LAST) begin
              s     <= '0;
              state <= IDLE;
            end else begin
              s <= s + 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Self-checking bench for uart_rx_cfg: directed scenarios plus randomized
// frames checked against a frame-level reference model.
module tb_uart_rx_cfg;

  localparam int DB = 8;
  localparam int OS = 16;
  localparam int TP = 2;  // clk cycles per tick

  typedef struct packed {
    logic [DB-1:0] data;
    logic          pe;
    logic          fe;
    logic          bd;
    logic          ov;
  } word_t;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          tick = 1'b0;
  logic          rx = 1'b1;
  logic [1:0]    parity_mode = 2'b00;
  logic          stop_bits = 1'b0;
  logic          rx_ready = 1'b1;
  logic [DB-1:0] rx_data;
  logic          rx_valid, parity_err, frame_err, break_det, overrun;

  int    tests = 0;
  int    fails = 0;
  int    vcyc  = 0;
  word_t got[$];

  uart_rx_cfg #(.DATA_BITS(DB), .OVERSAMPLE(OS)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .tick       (tick),
    .rx         (rx),
    .parity_mode(parity_mode),
    .stop_bits  (stop_bits),
    .rx_ready   (rx_ready),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .break_det  (break_det),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  initial begin : tick_gen
    int ph;
    ph = 0;
    forever begin
      @(posedge clk);
      #2;
      tick = (ph == 0);
      ph = (ph + 1) % TP;
    end
  end

  // Capture every accepted word, seen half a cycle before the handshake edge.
  always @(negedge clk) begin
    if (rx_valid) vcyc++;
    if (rx_valid && rx_ready) got.push_back({rx_data, parity_err, frame_err, break_det, overrun});
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic line(input logic v, input int ticks);
    rx = v;
    repeat (ticks * TP) begin
      @(posedge clk);
      #2;
    end
  endtask

  // Drives one frame and returns what the receiver should report for it.
  task automatic send_frame(input logic [DB-1:0] d, input logic [1:0] pm, input logic two,
                            input logic flip, input logic s1, input logic s2, input int gap,
                            output word_t exp);
    logic pen, pbit;
    parity_mode = pm;
    stop_bits   = two;
    pen  = (pm == 2'b01) || (pm == 2'b10);
    pbit = ((pm == 2'b10) ? ~(^d) : (^d)) ^ flip;
    line(1'b0, OS);
    parity_mode = 2'($urandom);
    stop_bits   = 1'($urandom);
    for (int i = 0; i < DB; i++) line(d[i], OS);
    if (pen) line(pbit, OS);
    line(s1, OS);
    if (two) line(s2, OS);
    line(1'b1, gap);
    exp.data = d;
    exp.pe   = pen && flip;
    exp.fe   = !s1 || (two && !s2);
    exp.bd   = (d == '0) && !(pen && pbit) && !s1;
    exp.ov   = 1'b0;
  endtask

  task automatic expect_word(input string tag, input word_t exp);
    word_t w;
    check({tag, " words"}, got.size(), 1);
    if (got.size() > 0) begin
      w = got.pop_front();
      check({tag, " data"}, w.data, exp.data);
      check({tag, " flags pe/fe/bd/ov"}, {w.pe, w.fe, w.bd, w.ov}, {exp.pe, exp.fe, exp.bd, exp.ov});
    end
    got.delete();
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, " rx_data"}, rx_data, 0);
    check({tag, " flags"}, {rx_valid, parity_err, frame_err, break_det, overrun}, 0);
  endtask

  initial begin
    word_t e;
    int    v0;

    repeat (3) @(posedge clk);
    #2;
    check_idle_outputs("reset");
    reset_n = 1'b1;
    line(1'b1, OS);

    // 8N1, one-cycle valid pulse with rx_ready high
    v0 = vcyc;
    send_frame(8'hA5, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, OS, e);
    expect_word("8N1 A5", e);
    check("8N1 valid cycles", vcyc - v0, 1);

    // Even and odd parity, correct and corrupted
    send_frame(8'h3C, 2'b01, 1'b0, 1'b0, 1'b1, 1'b1, OS, e);
    expect_word("8E1 ok", e);
    send_frame(8'h3C, 2'b01, 1'b0, 1'b1, 1'b1, 1'b1, OS, e);
    expect_word("8E1 bad", e);
    send_frame(8'h3C, 2'b10, 1'b0, 1'b0, 1'b1, 1'b1, OS, e);
    expect_word("8O1 ok", e);
    send_frame(8'h3C, 2'b10, 1'b0, 1'b1, 1'b1, 1'b1, OS, e);
    expect_word("8O1 bad", e);

    // Start-bit glitch is rejected, following frame still received
    line(1'b0, 5);
    line(1'b1, 2 * OS);
    check("glitch words", got.size(), 0);
    check("glitch valid", rx_valid, 0);
    send_frame(8'h55, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, OS, e);
    expect_word("after glitch 55", e);

    // Break: held low 12 bit times, then longer, no re-arm until high
    parity_mode = 2'b00;
    stop_bits   = 1'b0;
    line(1'b0, 12 * OS);
    e = '{data: '0, pe: 1'b0, fe: 1'b1, bd: 1'b1, ov: 1'b0};
    expect_word("break", e);
    line(1'b0, 12 * OS);
    check("break hold words", got.size(), 0);
    line(1'b1, 2 * OS);
    check("break release words", got.size(), 0);
    send_frame(8'hC3, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, OS, e);
    expect_word("after break C3", e);

    // Overrun with consumer stalled
    rx_ready = 1'b0;
    send_frame(8'h11, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, OS, e);
    send_frame(8'h22, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, OS, e);
    check("overrun held valid", rx_valid, 1);
    check("overrun held data", rx_data, 8'h22);
    check("overrun flag", overrun, 1);
    rx_ready = 1'b1;
    @(posedge clk);
    #2;
    rx_ready = 1'b0;
    check("overrun cleared valid", rx_valid, 0);
    check("overrun cleared flag", overrun, 0);
    e.ov = 1'b1;
    expect_word("overrun word", e);
    rx_ready = 1'b1;

    // Two stop bits, second one low
    send_frame(8'h96, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 2 * OS, e);
    expect_word("8N2 stop2 low", e);

    // Back-to-back frames half a bit after the stop sample
    send_frame(8'h0F, 2'b01, 1'b1, 1'b0, 1'b1, 1'b1, 0, e);
    expect_word("b2b first", e);
    send_frame(8'hF0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, OS, e);
    expect_word("b2b second", e);

    // Reset mid-DATA clears a held word and aborts the frame
    rx_ready = 1'b0;
    send_frame(8'h5A, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, OS, e);
    check("pre-reset valid", rx_valid, 1);
    line(1'b0, OS);
    line(1'b1, OS);
    line(1'b0, OS / 2);
    reset_n = 1'b0;
    rx = 1'b1;
    #1;
    check_idle_outputs("mid-frame reset");
    repeat (3) @(posedge clk);
    #2;
    reset_n  = 1'b1;
    rx_ready = 1'b1;
    line(1'b1, 2 * OS);
    check("no partial word", got.size(), 0);
    send_frame(8'h81, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, OS, e);
    expect_word("after reset 81", e);

    // Randomized frames against the reference model
    for (int k = 0; k < 20; k++) begin
      logic [DB-1:0] d;
      logic [1:0]    pm;
      logic          two, flip, s1;
      d    = DB'($urandom);
      if ($urandom_range(5, 0) == 0) d = '0;
      pm   = 2'($urandom);
      two  = 1'($urandom);
      flip = 1'($urandom);
      s1   = two ? ($urandom_range(3, 0) != 0) : 1'b1;
      send_frame(d, pm, two, flip, s1, 1'b1, $urandom_range(OS, 0), e);
      expect_word($sformatf("rand %0d", k), e);
    end

    line(1'b1, OS);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
